// File: rtl/sc_pkg.sv
// Shared constants and helpers for the basic-computer sequence counter.
// The counter width fixes the number of one-hot timing outputs (T_W = 2**CNT_W).
package sc_pkg;

    localparam int CNT_W = 4;
    localparam int T_W   = 16;

    localparam logic [CNT_W-1:0] SC_RESET_VAL = '0;

    // Reference decode of a count into its one-hot timing word.
    function automatic logic [T_W-1:0] onehot_decode(input logic [CNT_W-1:0] count);
        logic [T_W-1:0] w_t;
        w_t        = '0;
        w_t[count] = 1'b1;
        return w_t;
    endfunction

endpackage

// File: rtl/sc_decoder.sv
// Combinational CNT_W -> 2**CNT_W one-hot decoder producing the timing signals.
// Each output bit is an independent equality compare, so the width scales with CNT_W.
module sc_decoder #(
    parameter int CNT_W = 4,
    parameter int T_W   = 2**CNT_W
) (
    input  logic [CNT_W-1:0] i_count,
    output logic [T_W-1:0]   o_t
);

    for (genvar k = 0; k < T_W; k++) begin : g_dec
        assign o_t[k] = (i_count == CNT_W'(k));
    end

endmodule

// File: rtl/sequence_counter.sv
// Sequence counter stepping the controller through T0..T15 of each instruction.
// CLR returns to T0 and beats INR; the count wraps modulo 2**CNT_W with no flag.
module sequence_counter #(
    parameter int CNT_W = sc_pkg::CNT_W,
    parameter int T_W   = sc_pkg::T_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CLR,
    input  logic             INR,
    output logic [CNT_W-1:0] SC_VAL,
    output logic [T_W-1:0]   T
);

    import sc_pkg::SC_RESET_VAL;

    if (T_W != 2**CNT_W) begin : g_width_check
        $error("sequence_counter: T_W must equal 2**CNT_W");
    end

    logic [CNT_W-1:0] r_sc;
    logic [T_W-1:0]   w_t;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of r_sc regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc <= CNT_W'(SC_RESET_VAL);
        end else if (CLR) begin
            r_sc <= CNT_W'(SC_RESET_VAL);
        end else if (INR) begin
            r_sc <= r_sc + CNT_W'(1);
        end
    end

    sc_decoder #(
        .CNT_W (CNT_W),
        .T_W   (T_W)
    ) u_decoder (
        .i_count (r_sc),
        .o_t     (w_t)
    );

    assign SC_VAL = r_sc;
    assign T      = w_t;

endmodule

// File: tb/tb_sequence_counter.sv
// Self-checking bench: directed pins plus randomized CLR/INR against an integer model.
module tb_sequence_counter;

    logic        clk;
    logic        rst_n;
    logic        CLR;
    logic        INR;
    logic [3:0]  SC_VAL;
    logic [15:0] T;

    int n_vec;
    int n_mis;
    int m_sc;
    bit cmp_en;

    sequence_counter #(
        .CNT_W (4),
        .T_W   (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .CLR    (CLR),
        .INR    (INR),
        .SC_VAL (SC_VAL),
        .T      (T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the count as a plain integer, reduced modulo 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   m_sc = 0;
        else if (CLR) m_sc = 0;
        else if (INR) m_sc = (m_sc + 1) % 16;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_sc", 32'(SC_VAL), 32'(m_sc));
            check("model_t", 32'(T), 32'(1) << m_sc);
            check("onehot", 32'($onehot(T)), 32'd1);
        end
    end

    // Apply one edge's worth of request, then settle just past the edge.
    task automatic cycle(input logic c, input logic i);
        CLR = c;
        INR = i;
        @(posedge clk);
        #1;
    endtask

    task automatic set_count(input int n);
        cycle(1'b1, 1'b0);
        repeat (n) cycle(1'b0, 1'b1);
        CLR = 1'b0;
        INR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lit;
        n_vec  = 0;
        n_mis  = 0;
        m_sc   = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        CLR    = 1'b0;
        INR    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_sc", 32'(SC_VAL), 32'd0);
        check("reset_t", 32'(T), 32'h0001);
        #2 rst_n = 1'b1;
        INR = 1'b0;
        cmp_en = 1'b1;

        // Increment sweep: T0 -> T15 then wrap back to T0 on the 16th edge.
        cycle(1'b1, 1'b0);
        lit = 16'h0001;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 1'b1);
            lit = {lit[14:0], lit[15]};
            check("sweep_t", 32'(T), 32'(lit));
        end
        check("wrap_t", 32'(T), 32'h0001);

        // Hold at 3 for five clocks.
        set_count(3);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0);
            check("hold_t", 32'(T), 32'h0008);
        end

        // Clear from 5.
        set_count(5);
        check("pre_clear_t", 32'(T), 32'h0020);
        cycle(1'b1, 1'b0);
        check("clear_sc", 32'(SC_VAL), 32'd0);
        check("clear_t", 32'(T), 32'h0001);

        // CLR beats INR from 9.
        set_count(9);
        check("pre_prio_t", 32'(T), 32'h0200);
        cycle(1'b1, 1'b1);
        check("prio_sc", 32'(SC_VAL), 32'd0);
        check("prio_t", 32'(T), 32'h0001);

        // Asynchronous reset mid-count at 7, away from any clock edge.
        set_count(7);
        check("pre_rst_sc", 32'(SC_VAL), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sc", 32'(SC_VAL), 32'd0);
        check("async_rst_t", 32'(T), 32'h0001);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1);
            check("rst_hold_t", 32'(T), 32'h0001);
        end
        #2 rst_n = 1'b1;
        cycle(1'b0, 1'b1);
        check("post_rst_t", 32'(T), 32'h0002);

        // Randomized CLR/INR; the negedge compare process checks every cycle.
        for (int k = 0; k < 1000; k++) begin
            cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/sequence_counter.md
Name: sequence_counter

Overview:
- 4-bit sequence counter with a one-hot 4-to-16 timing decoder.
- Produces the timing signals T0..T15 that step the basic-computer controller through fetch, decode and execute.
- The controller increments it once per microstep and clears it at the end of each instruction.

Parameters:
- CNT_W, 4, counter width in bits.
- T_W, 16, number of timing outputs; must equal 2**CNT_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous clear request; SC <- 0.
- INR  input  1  synchronous increment request; SC <- SC + 1.
- SC_VAL  output  CNT_W  current registered count.
- T  output  T_W  one-hot decode of SC_VAL; T[k]=1 iff SC_VAL==k.

Behaviour:
- Reset:
  - rst_n low asynchronously forces SC_VAL=0, so T=16'h0001 (T0 active).
  - Outputs hold that value while rst_n is low.
  - Reset release is sampled normally; the first update happens on the first rising edge with rst_n high.
- On each rising clk edge with rst_n high:
  - CLR=1: SC_VAL <- 0. CLR has priority over INR when both are 1.
  - CLR=0, INR=1: SC_VAL <- SC_VAL+1, modulo 2**CNT_W.
  - CLR=0, INR=0: SC_VAL holds.
- Wrap-around: SC_VAL=15 with INR=1 gives 0 (T0) on the next edge. No flag, no saturation.
- T is a purely combinational decode of the SC_VAL register.
  - Exactly one bit of T is set at all times, including during reset.
  - Latency: T reflects a CLR/INR request one clock after it is sampled, i.e. in the cycle following the edge.
- CLR and INR are level-sampled at each edge; no handshake.
  - Holding INR high advances one step per clock.
  - Holding CLR high keeps T0 asserted.
- Reset mid-count: asserting rst_n at any count returns SC_VAL to 0 immediately, without waiting for a clock edge.
- X/unknown on CLR/INR is not a legal input. Treat as don't-care; the register stays in its legal 0..15 range.
- No internal state beyond the CNT_W-bit register.

Decomposition:
- Shared package sc_pkg: constants CNT_W=4, T_W=16, SC_RESET_VAL='0, and a function onehot_decode(count) returning T_W bits.
- One natural sub-module, sc_decoder: parameterised CNT_W -> 2**CNT_W one-hot decoder, purely combinational.
- sequence_counter instantiates sc_decoder on the SC_VAL register.
- Keep a generate-based decoder so T_W scales with CNT_W; add an elaboration check that T_W==2**CNT_W.

Test Plan:
- Reset: rst_n=0 mid-simulation while SC_VAL=7 -> SC_VAL=0 and T=16'h0001 immediately, no clock edge needed; stays there while rst_n=0.
- Increment sweep: rst_n=1, INR=1, CLR=0 for 16 clocks -> T walks 0x0001, 0x0002, ..., 0x8000, then 0x0001 on the 16th edge (wrap).
- Hold: SC_VAL=3, INR=0, CLR=0 for 5 clocks -> T stays 16'h0008.
- Clear: SC_VAL=5, CLR=1 for one edge -> SC_VAL=0, T=16'h0001 in the next cycle.
- Priority: SC_VAL=9, CLR=1 and INR=1 together -> SC_VAL=0, not 10.
- One-hot invariant: random CLR/INR for 1000 cycles against a reference model -> $onehot(T) always true and T==1<<SC_VAL every cycle.
